sram_arbiter: RTL

Two-to-one arbiter that merges the core's instruction and data SRAM-like request/response ports into a single shared SRAM-like memory port. It sits between the CPU core's `inst_sram_*` and `data_sram_*` interfaces and the memory or bridge side `mem_*` port. It arbitrates address-phase requests and locks a grant until the request is accepted. It records the owner of every accepted transaction in an in-order ID queue so that each `mem_data_ok` is routed back to the requester that issued it.

---
 rtl/sram_arbiter.sv | 115 +++++++++++
 1 files changed

// File: rtl/sram_arbiter.sv
// Two-to-one arbiter merging the core's instruction and data SRAM ports onto one
// shared memory port, with an in-order owner queue for routing data responses.
module sram_arbiter #(
   parameter int OUT_DEPTH = 4,
   parameter int PTR_W     = 2
) (
   input  logic        clk,
   input  logic        resetn,

   input  logic        inst_sram_req,
   input  logic        inst_sram_wr,
   input  logic [1:0]  inst_sram_size,
   input  logic [3:0]  inst_sram_wstrb,
   input  logic [31:0] inst_sram_addr,
   input  logic [31:0] inst_sram_wdata,
   output logic        inst_sram_addr_ok,
   output logic        inst_sram_data_ok,
   output logic [31:0] inst_sram_rdata,

   input  logic        data_sram_req,
   input  logic        data_sram_wr,
   input  logic [1:0]  data_sram_size,
   input  logic [3:0]  data_sram_wstrb,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic        data_sram_addr_ok,
   output logic        data_sram_data_ok,
   output logic [31:0] data_sram_rdata,

   output logic        mem_req,
   output logic        mem_wr,
   output logic [1:0]  mem_size,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_addr_ok,
   input  logic        mem_data_ok,
   input  logic [31:0] mem_rdata
);

   // state     | meaning
   // ST_OPEN   | no stalled request; grant follows fixed priority (data over inst)
   // ST_LOCKED | memory is stalling a request; grant held at lock_id until mem_addr_ok
   typedef enum logic {ST_OPEN = 1'b0, ST_LOCKED = 1'b1} lock_state_t;

   lock_state_t      state;
   logic             lock_id;
   logic             locked;
   logic             grant;
   logic             granted_req;
   logic             full;
   logic             push;
   logic             pop;
   logic             head;
   logic [PTR_W-1:0] wptr;
   logic [PTR_W-1:0] rptr;
   logic [PTR_W:0]   count;
   logic [OUT_DEPTH-1:0] id_q;

   assign locked      = (state == ST_LOCKED);
   assign grant       = locked ? lock_id : data_sram_req;
   assign granted_req = grant ? data_sram_req : inst_sram_req;
   // Registered count only, so a same-cycle pop never feeds back into mem_req.
   assign full        = (count == (PTR_W+1)'(OUT_DEPTH));

   assign mem_req   = granted_req && !full;
   assign mem_wr    = grant ? data_sram_wr    : inst_sram_wr;
   assign mem_size  = grant ? data_sram_size  : inst_sram_size;
   assign mem_wstrb = grant ? data_sram_wstrb : inst_sram_wstrb;
   assign mem_addr  = grant ? data_sram_addr  : inst_sram_addr;
   assign mem_wdata = grant ? data_sram_wdata : inst_sram_wdata;

   assign push = mem_req && mem_addr_ok;
   assign pop  = mem_data_ok && (count != '0);
   assign head = id_q[rptr];

   assign inst_sram_addr_ok = push && !grant;
   assign data_sram_addr_ok = push &&  grant;
   assign inst_sram_data_ok = pop && !head;
   assign data_sram_data_ok = pop &&  head;
   assign inst_sram_rdata   = mem_rdata;
   assign data_sram_rdata   = mem_rdata;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state   <= ST_OPEN;
         lock_id <= 1'b0;
      end else if (state == ST_OPEN) begin
         if (mem_req && !mem_addr_ok) begin
            state   <= ST_LOCKED;
            lock_id <= grant;
         end
      end else if (mem_addr_ok) begin
         state <= ST_OPEN;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         id_q  <= '0;
      end else begin
         if (push) begin
            id_q[wptr] <= grant;
            wptr       <= wptr + PTR_W'(1);
         end
         if (pop) rptr <= rptr + PTR_W'(1);
         if (push && !pop)      count <= count + (PTR_W+1)'(1);
         else if (!push && pop) count <= count - (PTR_W+1)'(1);
      end
   end

endmodule
